// File: rtl/fib_array_engine.sv
// Multi-channel iterative Fibonacci engine with start/busy/done handshake,
// per-channel saturation/overflow flags and a registered cross-channel total.
module fib_array_engine #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int SUM_W    = (WIDTH + $clog2(CHANNELS) > WIDTH + 1) ?
                             (WIDTH + $clog2(CHANNELS)) : (WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      reset_button,
    input  logic                      start,
    input  logic [CHANNELS*WIDTH-1:0] n_in,
    output logic                      busy,
    output logic                      done,
    output logic [CHANNELS*WIDTH-1:0] fib_out,
    output logic [CHANNELS-1:0]       ovf,
    output logic [SUM_W-1:0]          total_sum
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_SUM} state_t;

    localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic               r_done;
    logic [SUM_W-1:0]   r_total;
    logic [SUM_W-1:0]   w_total;
    logic [WIDTH-1:0]   w_a [CHANNELS];
    logic [CHANNELS-1:0] w_cnt_zero;
    logic               w_load;
    logic               w_step;

    assign w_load = (r_state == S_IDLE) && start;
    assign w_step = (r_state == S_RUN);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] r_a;
        logic [WIDTH-1:0] r_b;
        logic [WIDTH-1:0] r_cnt;
        logic             r_a_sat;
        logic             r_b_sat;
        logic [WIDTH:0]   w_add;

        // Extra bit exposes the carry that signals the true value no longer fits.
        assign w_add = {1'b0, r_a} + {1'b0, r_b};

        // NOTE: sequential state uses non-blocking assignments only, so every
        // register here sees the pre-edge value of its neighbours.
        always_ff @(posedge clk or posedge reset_button) begin
            if (reset_button) begin
                r_a     <= '0;
                r_b     <= '0;
                r_cnt   <= '0;
                r_a_sat <= 1'b0;
                r_b_sat <= 1'b0;
            end else if (w_load) begin
                r_cnt   <= n_in[g*WIDTH +: WIDTH];
                r_a     <= '0;
                r_b     <= L_ONE;
                r_a_sat <= 1'b0;
                r_b_sat <= 1'b0;
            end else if (w_step && (r_cnt != '0)) begin
                r_a     <= r_b;
                r_a_sat <= r_b_sat;
                r_cnt   <= r_cnt - L_ONE;
                if (w_add[WIDTH]) begin
                    r_b     <= '1;
                    r_b_sat <= 1'b1;
                end else begin
                    r_b     <= w_add[WIDTH-1:0];
                    r_b_sat <= r_b_sat | r_a_sat;
                end
            end
        end

        assign w_a[g]                    = r_a;
        assign w_cnt_zero[g]             = (r_cnt == '0);
        assign fib_out[g*WIDTH +: WIDTH] = r_a;
        assign ovf[g]                    = r_a_sat;
    end

    // Zero-extended sum is wide enough for CHANNELS full-scale values.
    always_comb begin
        w_total = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_total = w_total + SUM_W'(w_a[i]);
        end
    end

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: defaulting w_next_state before the case keeps this purely
    // combinational; a missing default path would infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_RUN;
            S_RUN:   if (&w_cnt_zero) w_next_state = S_SUM;
            S_SUM:   w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN) || (r_state == S_SUM);
    end

    always_ff @(posedge clk or posedge reset_button) begin
        if (reset_button) begin
            r_done  <= 1'b0;
            r_total <= '0;
        end else begin
            r_done <= (r_state == S_SUM);
            if (r_state == S_SUM) begin
                r_total <= w_total;
            end
        end
    end

    assign done      = r_done;
    assign total_sum = r_total;

endmodule

// File: tb/tb_fib_array_engine.sv
// Self-checking bench: a 2x8 and a 4x16 engine driven by directed and random
// runs, compared against a capped-arithmetic Fibonacci reference.
module tb_fib_array_engine;

    localparam int WA = 8;
    localparam int CA = 2;
    localparam int SA = 9;
    localparam int WB = 16;
    localparam int CB = 4;
    localparam int SB = 18;

    logic clk = 1'b0;
    logic reset_button = 1'b1;

    logic                a_start = 1'b0;
    logic [CA*WA-1:0]    a_n = '0;
    logic                a_busy, a_done;
    logic [CA*WA-1:0]    a_fib;
    logic [CA-1:0]       a_ovf;
    logic [SA-1:0]       a_sum;

    logic                b_start = 1'b0;
    logic [CB*WB-1:0]    b_n = '0;
    logic                b_busy, b_done;
    logic [CB*WB-1:0]    b_fib;
    logic [CB-1:0]       b_ovf;
    logic [SB-1:0]       b_sum;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fib_array_engine #(.WIDTH(WA), .CHANNELS(CA)) dut_a (
        .clk(clk), .reset_button(reset_button), .start(a_start), .n_in(a_n),
        .busy(a_busy), .done(a_done), .fib_out(a_fib), .ovf(a_ovf), .total_sum(a_sum)
    );

    fib_array_engine #(.WIDTH(WB), .CHANNELS(CB)) dut_b (
        .clk(clk), .reset_button(reset_button), .start(b_start), .n_in(b_n),
        .busy(b_busy), .done(b_done), .fib_out(b_fib), .ovf(b_ovf), .total_sum(b_sum)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // True F(n) clamped at 2^w: result == 2^w means the true value overflowed.
    function automatic longint fib_cap(input int n, input int w);
        longint cap = longint'(1) << w;
        longint a = 0;
        longint b = 1;
        longint t;
        for (int k = 0; k < n; k++) begin
            t = a + b;
            if (t > cap) t = cap;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int max2(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic start_a(input int n0, input int n1, input string tag);
        a_n     = {WA'(n1), WA'(n0)};
        a_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_start = 1'b0;
        check({tag, " busy after start"}, 64'(a_busy), 64'd1);
        check({tag, " fib cleared"}, 64'(a_fib), 64'd0);
        check({tag, " ovf cleared"}, 64'(a_ovf), 64'd0);
    endtask

    // Waits for done (bounded) and checks latency and results; returns at the done negedge.
    task automatic finish_a(input int n0, input int n1, input bit noise, input string tag);
        int     k = 0;
        longint f0, f1, v0, v1;
        longint cap = longint'(1) << WA;
        while (a_done !== 1'b1 && k < 600) begin
            if (noise) begin
                a_start = 1'($urandom_range(0, 1));
                a_n     = (CA*WA)'($urandom);
            end
            @(negedge clk);
            k++;
        end
        a_start = 1'b0;
        f0 = fib_cap(n0, WA);
        f1 = fib_cap(n1, WA);
        v0 = (f0 >= cap) ? cap - 1 : f0;
        v1 = (f1 >= cap) ? cap - 1 : f1;
        check({tag, " latency"}, 64'(k), 64'(max2(n0, n1) + 2));
        check({tag, " busy in done cycle"}, 64'(a_busy), 64'd0);
        check({tag, " fib0"}, 64'(a_fib[WA-1:0]), 64'(v0));
        check({tag, " fib1"}, 64'(a_fib[2*WA-1:WA]), 64'(v1));
        check({tag, " ovf"}, 64'(a_ovf), 64'({f1 >= cap, f0 >= cap}));
        check({tag, " total"}, 64'(a_sum), 64'(v0 + v1));
    endtask

    task automatic after_done_a(input string tag);
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(a_done), 64'd0);
        check({tag, " idle"}, 64'(a_busy), 64'd0);
    endtask

    task automatic run_b(input int n0, input int n1, input int n2, input int n3, input string tag);
        int          k = 0;
        int          n [CB];
        longint      f, v, s;
        logic [CB-1:0] o;
        longint      cap = longint'(1) << WB;
        n[0] = n0; n[1] = n1; n[2] = n2; n[3] = n3;
        b_n     = {WB'(n3), WB'(n2), WB'(n1), WB'(n0)};
        b_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        b_start = 1'b0;
        check({tag, " busy after start"}, 64'(b_busy), 64'd1);
        while (b_done !== 1'b1 && k < 600) begin
            @(negedge clk);
            k++;
        end
        check({tag, " latency"}, 64'(k), 64'(max2(max2(n0, n1), max2(n2, n3)) + 2));
        s = 0;
        o = '0;
        for (int i = 0; i < CB; i++) begin
            f = fib_cap(n[i], WB);
            v = (f >= cap) ? cap - 1 : f;
            o[i] = (f >= cap);
            s += v;
            check($sformatf("%s fib%0d", tag, i), 64'(b_fib[i*WB +: WB]), 64'(v));
        end
        check({tag, " ovf"}, 64'(b_ovf), 64'(o));
        check({tag, " total"}, 64'(b_sum), 64'(s));
        @(negedge clk);
        check({tag, " done one cycle"}, 64'(b_done), 64'd0);
    endtask

    initial begin
        int r0, r1, dones;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("reset busy", 64'(a_busy), 64'd0);
        check("reset done", 64'(a_done), 64'd0);
        check("reset fib", 64'(a_fib), 64'd0);
        check("reset ovf", 64'(a_ovf), 64'd0);
        check("reset total", 64'(a_sum), 64'd0);
        reset_button = 1'b0;
        @(negedge clk);

        // Basic run
        start_a(7, 10, "basic");
        finish_a(7, 10, 1'b0, "basic");
        after_done_a("basic");

        // Saturation boundary, with start pulses and n_in churn while busy
        start_a(13, 14, "sat");
        finish_a(13, 14, 1'b1, "sat");
        after_done_a("sat");

        // Trivial inputs, then results hold in IDLE
        start_a(0, 1, "trivial");
        finish_a(0, 1, 1'b0, "trivial");
        after_done_a("trivial");
        repeat (3) @(negedge clk);
        check("hold fib", 64'(a_fib), 64'({8'd1, 8'd0}));
        check("hold total", 64'(a_sum), 64'd1);

        start_a(0, 0, "zero");
        finish_a(0, 0, 1'b0, "zero");
        after_done_a("zero");

        // Back-to-back: second start issued in the done cycle
        start_a(2, 3, "b2b first");
        finish_a(2, 3, 1'b0, "b2b first");
        start_a(5, 6, "b2b second");
        finish_a(5, 6, 1'b1, "b2b second");
        after_done_a("b2b second");

        // Scale check on the 4x16 instance
        run_b(24, 25, 1, 0, "scale");

        // Asynchronous reset mid-run
        start_a(10, 10, "abort");
        repeat (4) @(negedge clk);
        #2 reset_button = 1'b1;
        #1;
        check("abort busy", 64'(a_busy), 64'd0);
        check("abort done", 64'(a_done), 64'd0);
        check("abort fib", 64'(a_fib), 64'd0);
        check("abort ovf", 64'(a_ovf), 64'd0);
        check("abort total", 64'(a_sum), 64'd0);
        check("abort total b", 64'(b_sum), 64'd0);
        @(negedge clk);
        reset_button = 1'b0;
        dones = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (a_done === 1'b1) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);
        check("abort idle", 64'(a_busy), 64'd0);
        start_a(3, 4, "post abort");
        finish_a(3, 4, 1'b0, "post abort");
        after_done_a("post abort");

        // Random runs
        for (int i = 0; i < 6; i++) begin
            r0 = int'($urandom_range(0, 20));
            r1 = int'($urandom_range(0, 20));
            start_a(r0, r1, "rand small");
            finish_a(r0, r1, 1'($urandom_range(0, 1)), "rand small");
            after_done_a("rand small");
        end
        for (int i = 0; i < 2; i++) begin
            r0 = int'($urandom_range(0, 255));
            r1 = int'($urandom_range(0, 255));
            start_a(r0, r1, "rand wide");
            finish_a(r0, r1, 1'b1, "rand wide");
            after_done_a("rand wide");
        end
        for (int i = 0; i < 3; i++) begin
            run_b(int'($urandom_range(0, 30)), int'($urandom_range(0, 30)),
                  int'($urandom_range(0, 30)), int'($urandom_range(0, 30)), "rand b");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_array_engine.md
Name: fib_array_engine

Overview:
- Parametrised multi-channel Fibonacci engine, the next generation of the two-channel Fibonacci ASIC.
- Each channel computes F(n) iteratively with a down-counter, with no stack.
- Adds generic width and channel count, a start/busy/done handshake, per-channel saturation and overflow flags, and a registered cross-channel total.
- Sits as the datapath core under the top-level ASIC wrapper.

Parameters:
- WIDTH, 8: bit width of each n input and each F(n) result.
- CHANNELS, 2: number of independent Fibonacci channels (>=1).
- SUM_W, WIDTH+$clog2(CHANNELS) (minimum WIDTH+1): width of total_sum.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_button  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- n_in  in  CHANNELS*WIDTH  per-channel index n; channel i is bits [i*WIDTH +: WIDTH].
- busy  out  1  high in RUN and SUM.
- done  out  1  one-cycle completion pulse.
- fib_out  out  CHANNELS*WIDTH  per-channel result, saturated F(n).
- ovf  out  CHANNELS  per-channel flag: true F(n) exceeded 2^WIDTH-1.
- total_sum  out  SUM_W  sum of all fib_out values.

Behaviour:
- Definition: F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
- Reset: while reset_button is high, regardless of clk:
  - FSM goes to IDLE.
  - busy, done, fib_out, ovf and total_sum are 0.
  - All channel registers are cleared.
  - Reset mid-run aborts the run; no done is produced.
- Per-channel registers: a (WIDTH), b (WIDTH), cnt (WIDTH), a_sat, b_sat.
- fib_out[i] = a[i]; ovf[i] = a_sat[i].
- FSM states: IDLE, RUN, SUM.
- IDLE:
  - On start=1: for every channel, latch cnt<=n_in[i], a<=0, b<=1, a_sat<=0, b_sat<=0; go to RUN.
  - start=0: hold, and keep the previous results visible.
- RUN, per channel, each cycle:
  - If cnt!=0: a<=b, a_sat<=b_sat, b<=sat(a+b), cnt<=cnt-1.
  - sat(x): if the (WIDTH+1)-bit sum carries out, b<={WIDTH{1}} and b_sat<=1. Otherwise b<=sum, and b_sat keeps its value, OR-ed with a_sat.
  - If cnt==0: channel holds.
  - Leave RUN for SUM in the cycle in which every channel has cnt==0 (checked before update).
  - RUN therefore lasts max(max_i n_i, 1)... more precisely max_i n_i cycles plus the exit cycle.
- SUM (1 cycle): total_sum <= zero-extended sum of all a[i] at SUM_W, which never overflows. Then go to IDLE.
- done: registered; high for exactly the first IDLE cycle after SUM.
  - A start in that same cycle is accepted.
  - done and busy are never high together.
- Latency: done is high on the cycle beginning max_i(n_i)+2 edges after the start-sampling edge.
  - n=0 on every channel gives done 2 cycles after start, with fib_out=0.
- Busy:
  - start while busy is ignored.
  - n_in is only sampled at the accepting edge; changes during a run have no effect.
- Outputs fib_out, ovf and total_sum hold their values in IDLE until the next accepted start.
  - On the accepting edge, fib_out and ovf clear to 0.
  - total_sum keeps its old value until the next SUM.
- Saturation is sticky within a run: once a channel saturates, it stays at {WIDTH{1}} with ovf=1.

Test Plan:
- Basic run (CHANNELS=2, WIDTH=8): n=7,10; start pulse -> fib_out=13,55; ovf=00; total_sum=68; done one cycle, 12 cycles after start edge.
- Saturation boundary: n=13,14 -> fib_out=233,255; ovf=10 (channel 1 set); total_sum=488 (9-bit).
- Trivial inputs: n=0,1 -> fib_out=0,1; ovf=0; total_sum=1; done 3 cycles after start.
- Back-to-back: start asserted in the done cycle with n=5,6 -> accepted; busy next cycle; result 5,8, total 13. Start pulses during busy are ignored, with no second done.
- Reset mid-run: n=10,10, assert reset_button asynchronously at RUN cycle 4 -> all outputs 0 immediately, FSM IDLE, no done. A following start with n=3,4 gives 2,3 and total 5.
- Scale check: CHANNELS=4, WIDTH=16, n=24,25,1,0 -> 46368,65535 with ovf bit1=1, then 1,0; total_sum=111904 (18-bit).
